// File: rtl/n1_sbus_arb.sv
// n1_sbus_arb -- stack bus arbiter for the N1 processor.
//
// Shares the single pipelined Wishbone stack bus (sbus) between the
// intermediate parameter stack (PS) and the intermediate return stack (RS).
// Ownership is granted for a whole bus cycle (cyc high) with no preemption.
// Once granted, all paths between the owner and the sbus are purely
// combinational; only the owner select and the fairness flag are registered.
//
// Ports:
//   clk_i, sync_rst_i              clock, synchronous active-high reset
//   ps_{cyc,stb,we,adr,dat}_i      PS initiator request
//   ps_{ack,err,rty,stall}_o       PS target responses
//   ps_dat_o                       PS read data (sbus_dat_i forwarded)
//   rs_*                           RS initiator, same meaning as PS
//   sbus_{cyc,stb,we,adr,dat}_o    shared bus initiator signals
//   sbus_tga_{ps,rs}_o             owner tags
//   sbus_{ack,err,rty,stall,dat}_i shared target responses / read data
//   prb_sarb_state_o               FSM state probe (the state register)
module n1_sbus_arb #(
  parameter int SP_WIDTH = 12
) (
  input  logic                clk_i,
  input  logic                sync_rst_i,
  // PS initiator
  input  logic                ps_cyc_i,
  input  logic                ps_stb_i,
  input  logic                ps_we_i,
  input  logic [SP_WIDTH-1:0] ps_adr_i,
  input  logic [15:0]         ps_dat_i,
  output logic                ps_ack_o,
  output logic                ps_err_o,
  output logic                ps_rty_o,
  output logic                ps_stall_o,
  output logic [15:0]         ps_dat_o,
  // RS initiator
  input  logic                rs_cyc_i,
  input  logic                rs_stb_i,
  input  logic                rs_we_i,
  input  logic [SP_WIDTH-1:0] rs_adr_i,
  input  logic [15:0]         rs_dat_i,
  output logic                rs_ack_o,
  output logic                rs_err_o,
  output logic                rs_rty_o,
  output logic                rs_stall_o,
  output logic [15:0]         rs_dat_o,
  // shared stack bus
  output logic                sbus_cyc_o,
  output logic                sbus_stb_o,
  output logic                sbus_we_o,
  output logic [SP_WIDTH-1:0] sbus_adr_o,
  output logic [15:0]         sbus_dat_o,
  output logic                sbus_tga_ps_o,
  output logic                sbus_tga_rs_o,
  input  logic                sbus_ack_i,
  input  logic                sbus_err_i,
  input  logic                sbus_rty_i,
  input  logic                sbus_stall_i,
  input  logic [15:0]         sbus_dat_i,
  // probe
  output logic [1:0]          prb_sarb_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PS   = 2'b01,
    ST_RS   = 2'b10
  } state_t;

  state_t state_q, state_d;
  logic   last_rs_q, last_rs_d;

  // Next-state logic. An owner keeps the bus while its cyc is high; on
  // release the other requester is preferred, otherwise the bus goes idle
  // (the releasing owner cannot re-request in the same cycle).
  always_comb begin
    state_d   = state_q;
    last_rs_d = last_rs_q;
    case (state_q)
      ST_PS: begin
        if (!ps_cyc_i) begin
          if (rs_cyc_i) begin
            state_d   = ST_RS;
            last_rs_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_RS: begin
        if (!rs_cyc_i) begin
          if (ps_cyc_i) begin
            state_d   = ST_PS;
            last_rs_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        // IDLE (and the unreachable 2'b11 encoding). On a tie PS wins
        // while last_rs is clear, so PS goes first out of reset.
        if (ps_cyc_i && (!rs_cyc_i || !last_rs_q)) begin
          state_d   = ST_PS;
          last_rs_d = 1'b0;
        end else if (rs_cyc_i) begin
          state_d   = ST_RS;
          last_rs_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      state_q   <= ST_IDLE;
      last_rs_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_rs_q <= last_rs_d;
    end
  end

  // Bus multiplexing. Defaults are the idle values: nothing on the sbus
  // and both initiators stalled with no responses.
  always_comb begin
    sbus_cyc_o    = 1'b0;
    sbus_stb_o    = 1'b0;
    sbus_we_o     = 1'b0;
    sbus_adr_o    = '0;
    sbus_dat_o    = '0;
    sbus_tga_ps_o = 1'b0;
    sbus_tga_rs_o = 1'b0;
    ps_ack_o      = 1'b0;
    ps_err_o      = 1'b0;
    ps_rty_o      = 1'b0;
    ps_stall_o    = 1'b1;
    rs_ack_o      = 1'b0;
    rs_err_o      = 1'b0;
    rs_rty_o      = 1'b0;
    rs_stall_o    = 1'b1;
    case (state_q)
      ST_PS: begin
        sbus_cyc_o    = ps_cyc_i;
        // stb is qualified by cyc so a dangling strobe never reaches the bus
        sbus_stb_o    = ps_cyc_i & ps_stb_i;
        sbus_we_o     = ps_we_i;
        sbus_adr_o    = ps_adr_i;
        sbus_dat_o    = ps_dat_i;
        sbus_tga_ps_o = 1'b1;
        ps_ack_o      = sbus_ack_i;
        ps_err_o      = sbus_err_i;
        ps_rty_o      = sbus_rty_i;
        ps_stall_o    = sbus_stall_i;
      end
      ST_RS: begin
        sbus_cyc_o    = rs_cyc_i;
        sbus_stb_o    = rs_cyc_i & rs_stb_i;
        sbus_we_o     = rs_we_i;
        sbus_adr_o    = rs_adr_i;
        sbus_dat_o    = rs_dat_i;
        sbus_tga_rs_o = 1'b1;
        rs_ack_o      = sbus_ack_i;
        rs_err_o      = sbus_err_i;
        rs_rty_o      = sbus_rty_i;
        rs_stall_o    = sbus_stall_i;
      end
      default: ;
    endcase
  end

  // Read data goes to both stacks unchanged; only the owner gets an ack.
  assign ps_dat_o         = sbus_dat_i;
  assign rs_dat_o         = sbus_dat_i;
  assign prb_sarb_state_o = state_q;

endmodule

// File: tb/tb_n1_sbus_arb.sv
module tb_n1_sbus_arb;

    logic        clk;
    logic        sync_rst;
    logic        ps_cyc, ps_stb, ps_we;
    logic [11:0] ps_adr;
    logic [15:0] ps_dat;
    logic        ps_ack, ps_err, ps_rty, ps_stall;
    logic [15:0] ps_rdat;
    logic        rs_cyc, rs_stb, rs_we;
    logic [11:0] rs_adr;
    logic [15:0] rs_dat;
    logic        rs_ack, rs_err, rs_rty, rs_stall;
    logic [15:0] rs_rdat;
    logic        s_cyc, s_stb, s_we;
    logic [11:0] s_adr;
    logic [15:0] s_dat;
    logic        s_tga_ps, s_tga_rs;
    logic        s_ack, s_err, s_rty, s_stall;
    logic [15:0] s_rdat;
    logic [1:0]  prb;

    int n_cmp = 0;
    int n_bad = 0;
    logic done = 1'b0;

    n1_sbus_arb #(.SP_WIDTH(12)) dut (
        .clk_i(clk), .sync_rst_i(sync_rst),
        .ps_cyc_i(ps_cyc), .ps_stb_i(ps_stb), .ps_we_i(ps_we),
        .ps_adr_i(ps_adr), .ps_dat_i(ps_dat),
        .ps_ack_o(ps_ack), .ps_err_o(ps_err), .ps_rty_o(ps_rty),
        .ps_stall_o(ps_stall), .ps_dat_o(ps_rdat),
        .rs_cyc_i(rs_cyc), .rs_stb_i(rs_stb), .rs_we_i(rs_we),
        .rs_adr_i(rs_adr), .rs_dat_i(rs_dat),
        .rs_ack_o(rs_ack), .rs_err_o(rs_err), .rs_rty_o(rs_rty),
        .rs_stall_o(rs_stall), .rs_dat_o(rs_rdat),
        .sbus_cyc_o(s_cyc), .sbus_stb_o(s_stb), .sbus_we_o(s_we),
        .sbus_adr_o(s_adr), .sbus_dat_o(s_dat),
        .sbus_tga_ps_o(s_tga_ps), .sbus_tga_rs_o(s_tga_rs),
        .sbus_ack_i(s_ack), .sbus_err_i(s_err), .sbus_rty_i(s_rty),
        .sbus_stall_i(s_stall), .sbus_dat_i(s_rdat),
        .prb_sarb_state_o(prb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: wait expired before test completion");
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    end

    typedef struct {
        logic        rst;
        logic [2:0]  ps;
        logic [11:0] ps_adr;
        logic [15:0] ps_dat;
        logic [2:0]  rs;
        logic [11:0] rs_adr;
        logic [15:0] rs_dat;
        logic [3:0]  resp;
        logic [15:0] sdat;
        logic [1:0]  e_st;
        logic [2:0]  e_sb;
        logic [11:0] e_adr;
        logic [15:0] e_dat;
        logic [1:0]  e_tga;
        logic [3:0]  e_ps;
        logic [3:0]  e_rs;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input vec_t v);
        vecs.push_back(v);
    endtask

    logic [81:0] act, exp_v;
    logic [46:0] rst_act, rst_exp;

    initial begin
        add('{1'b0, 3'b000, 12'h000, 16'h0000, 3'b000, 12'h000, 16'h0000, 4'b1000, 16'h5A5A, 2'b00, 3'b000, 12'h000, 16'h0000, 2'b00, 4'b0001, 4'b0001});
        add('{1'b0, 3'b111, 12'h123, 16'hBEEF, 3'b000, 12'h000, 16'h0000, 4'b0000, 16'h5A5A, 2'b00, 3'b000, 12'h000, 16'h0000, 2'b00, 4'b0001, 4'b0001});
        add('{1'b0, 3'b111, 12'h123, 16'hBEEF, 3'b000, 12'h000, 16'h0000, 4'b0000, 16'h5A5A, 2'b01, 3'b111, 12'h123, 16'hBEEF, 2'b10, 4'b0000, 4'b0001});
        add('{1'b0, 3'b111, 12'h123, 16'hBEEF, 3'b000, 12'h000, 16'h0000, 4'b1000, 16'h5A5A, 2'b01, 3'b111, 12'h123, 16'hBEEF, 2'b10, 4'b1000, 4'b0001});
        add('{1'b0, 3'b111, 12'h123, 16'hBEEF, 3'b110, 12'h0AA, 16'h1111, 4'b0001, 16'h5A5A, 2'b01, 3'b111, 12'h123, 16'hBEEF, 2'b10, 4'b0001, 4'b0001});
        add('{1'b0, 3'b111, 12'h123, 16'hBEEF, 3'b110, 12'h0AA, 16'h1111, 4'b1001, 16'h5A5A, 2'b01, 3'b111, 12'h123, 16'hBEEF, 2'b10, 4'b1001, 4'b0001});
        add('{1'b0, 3'b111, 12'h123, 16'hBEEF, 3'b110, 12'h0AA, 16'h1111, 4'b0111, 16'h5A5A, 2'b01, 3'b111, 12'h123, 16'hBEEF, 2'b10, 4'b0111, 4'b0001});
        add('{1'b0, 3'b101, 12'h123, 16'hBEEF, 3'b110, 12'h0AA, 16'h1111, 4'b0000, 16'h5A5A, 2'b01, 3'b101, 12'h123, 16'hBEEF, 2'b10, 4'b0000, 4'b0001});
        add('{1'b0, 3'b000, 12'h123, 16'hBEEF, 3'b110, 12'h0AA, 16'h1111, 4'b0000, 16'h5A5A, 2'b01, 3'b000, 12'h123, 16'hBEEF, 2'b10, 4'b0000, 4'b0001});
        add('{1'b0, 3'b000, 12'h123, 16'hBEEF, 3'b110, 12'h0AA, 16'h1111, 4'b0100, 16'hA5A5, 2'b10, 3'b110, 12'h0AA, 16'h1111, 2'b01, 4'b0001, 4'b0100});
        add('{1'b0, 3'b111, 12'h321, 16'hCAFE, 3'b110, 12'h0AA, 16'h1111, 4'b0010, 16'h5A5A, 2'b10, 3'b110, 12'h0AA, 16'h1111, 2'b01, 4'b0001, 4'b0010});
        add('{1'b0, 3'b111, 12'h321, 16'hCAFE, 3'b000, 12'h0AA, 16'h1111, 4'b0000, 16'h5A5A, 2'b10, 3'b000, 12'h0AA, 16'h1111, 2'b01, 4'b0001, 4'b0000});
        add('{1'b0, 3'b111, 12'h321, 16'hCAFE, 3'b000, 12'h0AA, 16'h1111, 4'b0000, 16'h5A5A, 2'b01, 3'b111, 12'h321, 16'hCAFE, 2'b10, 4'b0000, 4'b0001});
        add('{1'b0, 3'b000, 12'h321, 16'hCAFE, 3'b000, 12'h0AA, 16'h1111, 4'b0000, 16'h5A5A, 2'b01, 3'b000, 12'h321, 16'hCAFE, 2'b10, 4'b0000, 4'b0001});
        add('{1'b0, 3'b111, 12'h321, 16'hCAFE, 3'b000, 12'h0AA, 16'h1111, 4'b0000, 16'h5A5A, 2'b00, 3'b000, 12'h000, 16'h0000, 2'b00, 4'b0001, 4'b0001});
        add('{1'b0, 3'b111, 12'h321, 16'hCAFE, 3'b000, 12'h0AA, 16'h1111, 4'b0000, 16'h5A5A, 2'b01, 3'b111, 12'h321, 16'hCAFE, 2'b10, 4'b0000, 4'b0001});
        add('{1'b1, 3'b111, 12'h321, 16'hCAFE, 3'b000, 12'h0AA, 16'h1111, 4'b0000, 16'h5A5A, 2'b01, 3'b111, 12'h321, 16'hCAFE, 2'b10, 4'b0000, 4'b0001});
        add('{1'b1, 3'b111, 12'h321, 16'hCAFE, 3'b000, 12'h0AA, 16'h1111, 4'b1000, 16'h5A5A, 2'b00, 3'b000, 12'h000, 16'h0000, 2'b00, 4'b0001, 4'b0001});
        add('{1'b0, 3'b000, 12'h000, 16'h0000, 3'b000, 12'h000, 16'h0000, 4'b1000, 16'h5A5A, 2'b00, 3'b000, 12'h000, 16'h0000, 2'b00, 4'b0001, 4'b0001});
        add('{1'b0, 3'b111, 12'h111, 16'h0001, 3'b111, 12'h222, 16'h0002, 4'b0000, 16'h5A5A, 2'b00, 3'b000, 12'h000, 16'h0000, 2'b00, 4'b0001, 4'b0001});
        add('{1'b0, 3'b111, 12'h111, 16'h0001, 3'b111, 12'h222, 16'h0002, 4'b0000, 16'h5A5A, 2'b01, 3'b111, 12'h111, 16'h0001, 2'b10, 4'b0000, 4'b0001});
        add('{1'b0, 3'b000, 12'h111, 16'h0001, 3'b111, 12'h222, 16'h0002, 4'b0000, 16'h5A5A, 2'b01, 3'b000, 12'h111, 16'h0001, 2'b10, 4'b0000, 4'b0001});
        add('{1'b0, 3'b000, 12'h111, 16'h0001, 3'b111, 12'h222, 16'h0002, 4'b0000, 16'h5A5A, 2'b10, 3'b111, 12'h222, 16'h0002, 2'b01, 4'b0001, 4'b0000});
        add('{1'b0, 3'b000, 12'h111, 16'h0001, 3'b000, 12'h222, 16'h0002, 4'b0000, 16'h5A5A, 2'b10, 3'b000, 12'h222, 16'h0002, 2'b01, 4'b0001, 4'b0000});
        add('{1'b0, 3'b000, 12'h000, 16'h0000, 3'b000, 12'h000, 16'h0000, 4'b0000, 16'h5A5A, 2'b00, 3'b000, 12'h000, 16'h0000, 2'b00, 4'b0001, 4'b0001});

        sync_rst = 1'b1;
        {ps_cyc, ps_stb, ps_we} = 3'b000; ps_adr = '0; ps_dat = '0;
        {rs_cyc, rs_stb, rs_we} = 3'b000; rs_adr = '0; rs_dat = '0;
        {s_ack, s_err, s_rty, s_stall} = 4'b0000; s_rdat = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_act = {prb, s_cyc, s_stb, s_we, s_adr, s_dat, s_tga_ps, s_tga_rs,
                   ps_ack, ps_err, ps_rty, ps_stall, rs_ack, rs_err, rs_rty, rs_stall};
        rst_exp = {2'b00, 3'b000, 12'h000, 16'h0000, 2'b00, 4'b0001, 4'b0001};
        n_cmp++;
        if (rst_act !== rst_exp) begin
            n_bad++;
            $display("FAIL reset: got %h, want %h", rst_act, rst_exp);
        end else begin
            $display("reset ok: st=%b stalls=%b%b", prb, ps_stall, rs_stall);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            sync_rst = vecs[i].rst;
            {ps_cyc, ps_stb, ps_we} = vecs[i].ps;
            ps_adr = vecs[i].ps_adr;
            ps_dat = vecs[i].ps_dat;
            {rs_cyc, rs_stb, rs_we} = vecs[i].rs;
            rs_adr = vecs[i].rs_adr;
            rs_dat = vecs[i].rs_dat;
            {s_ack, s_err, s_rty, s_stall} = vecs[i].resp;
            s_rdat = vecs[i].sdat;
            #3;
            act = {prb, s_cyc, s_stb, s_we, s_adr, s_dat, s_tga_ps, s_tga_rs,
                   ps_ack, ps_err, ps_rty, ps_stall, rs_ack, rs_err, rs_rty, rs_stall,
                   ps_rdat, rs_rdat};
            exp_v = {vecs[i].e_st, vecs[i].e_sb, vecs[i].e_adr, vecs[i].e_dat, vecs[i].e_tga,
                     vecs[i].e_ps, vecs[i].e_rs, vecs[i].sdat, vecs[i].sdat};
            n_cmp++;
            if (act !== exp_v) begin
                n_bad++;
                $display("FAIL vec%0d: got st=%b sb=%b adr=%h dat=%h tga=%b ps=%b rs=%b prd=%h rrd=%h, want %h", i,
                         prb, {s_cyc, s_stb, s_we}, s_adr, s_dat, {s_tga_ps, s_tga_rs},
                         {ps_ack, ps_err, ps_rty, ps_stall}, {rs_ack, rs_err, rs_rty, rs_stall},
                         ps_rdat, rs_rdat, exp_v);
            end else begin
                $display("vec%0d ok: st=%b sb=%b adr=%h dat=%h", i, prb, {s_cyc, s_stb, s_we}, s_adr, s_dat);
            end
        end

        done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
